fs_serial_sub_ctrl: RTL and testbench
=====================================

Name: fs_serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller.
- Sequences one 1-bit full-subtractor cell over W cycles, LSB first, and computes diff = a - b - bin with borrow-out.
- Sits beside the existing combinational subtractor cells as the area-cheap multi-bit option, using a start/busy/done handshake toward its requester.

Parameters:
- W, 8, operand/result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  minuend; captured on accepted start.
- b  input  W  subtrahend; captured on accepted start.
- bin  input  1  initial borrow-in; captured on accepted start.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  W  result; held stable from done until the next accepted start.
- bout  output  1  final borrow-out; same validity as diff.

Behaviour:
- Reset: rst=1 at a clock edge forces state to IDLE and clears busy, done, diff, bout, the internal borrow flop, the operand shift registers and the bit counter to 0. This applies in any state, including mid-RUN; the operation in progress is discarded.
- States:
  - IDLE: waits for start.
  - RUN: performs one bit per cycle.
  - DONE: result cycle.
- Transitions:
  - IDLE -> RUN on start=1. On the same edge: latch a and b into shift registers, bin into the borrow flop, counter = 0.
  - RUN -> RUN while counter < W-1. Each edge:
    - the cell computes d = a_sh[0] ^ b_sh[0] ^ borrow.
    - it computes next borrow = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
    - d shifts into diff_sh MSB, diff_sh shifts right, a_sh and b_sh shift right, borrow updates, counter increments.
  - RUN -> DONE on the edge where counter = W-1, after the final bit is processed. On that edge: diff <= final diff_sh, bout <= final borrow, done <= 1.
  - DONE -> RUN if start=1, with the same capture as from IDLE. This allows back-to-back operations with no IDLE gap.
  - DONE -> IDLE otherwise. done returns to 0 in the next cycle in both cases.
- Timing: start accepted at edge 0 -> busy high in cycles 1..W -> done high in cycle W+1. Latency is W+1 cycles from start to done.
- start while in RUN is ignored and has no effect on the running operation.
- a, b and bin are don't-care except on the accepting edge.
- diff and bout do not change during RUN; they update only on the RUN -> DONE edge.
- W=1: RUN lasts exactly one cycle.
- Counter width is $clog2(W) with a minimum of 1; the count never reaches or wraps past W-1.
- Arithmetic is modulo 2^W. bout=1 exactly when a < b + bin as unsigned values.

Optional Feature:
- Macro: FS_SERIAL_SUB_OVF_EN.
- With the macro defined:
  - Adds output ovf (1 bit).
  - ovf is the two's-complement signed overflow of a - b - bin: (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]).
  - ovf uses captured copies of the operand MSBs, since the shift registers are consumed during RUN.
  - ovf is updated on the same edge as diff, cleared by reset, and held with diff.
- Without the macro: no ovf port and no MSB capture flops. All other behaviour is identical.

Decomposition:
- Shared package fs_serial_pkg containing:
  - State enum type: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function for the counter width given W.
- Sub-module fs_bit_cell: combinational 1-bit full subtractor (ai, bi, borrow_in -> d, borrow_out), instantiated once.
- The controller holds the FSM, shift registers, borrow flop, counter and output registers.

Test Plan:
- W=8, a=8'h5A, b=8'h3C, bin=0, start one cycle -> busy high cycles 1..8, done pulse cycle 9, diff=8'h1E, bout=0.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0.
- Start pulsed again in cycles 3 and 5 of a RUN with different operands -> ignored; result matches the first operands, done exactly once.
- Start held high in the DONE cycle with a=8'h03, b=8'h05 -> new RUN begins immediately; next done 9 cycles later, diff=8'hFE, bout=1; the first result is held through the second RUN.
- rst=1 in cycle 4 of RUN -> next cycle: IDLE, busy=0, done=0, diff=0, bout=0; a following start computes correctly. Also W=1, a=0, b=1 -> done at cycle 2, diff=1, bout=1.
- FS_SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1. a=8'h05, b=8'h03 -> ovf=0.

Source files
------------

// File: rtl/fs_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fs_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width for a W-bit operation; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = ai - bi - borrow_in.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
module fs_bit_cell (
   input  logic ai,
   input  logic bi,
   input  logic borrow_in,
   output logic d,
   output logic borrow_out
);

   // Difference bit and borrow generation/propagation.
   always_comb begin
      d          = ai ^ bi ^ borrow_in;
      borrow_out = (~ai & bi) | (~(ai ^ bi) & borrow_in);
   end

endmodule

// File: rtl/fs_serial_sub_ctrl.sv
// Bit-serial W-bit subtractor (diff = a - b - bin, LSB first); optional ovf via FS_SERIAL_SUB_OVF_EN.
// Latency: W+1 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is only taken in IDLE/DONE; start during RUN is ignored.
module fs_serial_sub_ctrl
   import fs_serial_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
`ifdef FS_SERIAL_SUB_OVF_EN
   output logic         ovf,
`endif
   output logic         bout
);

   localparam int            CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t         state;
   state_t         state_nxt;
   logic           accept;
   logic           finish;

   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   diff_sh;
   logic [W-1:0]   diff_sh_nxt;
   logic           borrow;
   logic [CW-1:0]  cnt;

   logic           cell_d;
   logic           cell_bout;

`ifdef FS_SERIAL_SUB_OVF_EN
   // Operand sign bits, kept because the shift registers are consumed in RUN.
   logic           a_msb;
   logic           b_msb;
`endif

   fs_bit_cell u_cell (
      .ai         (a_sh[0]),
      .bi         (b_sh[0]),
      .borrow_in  (borrow),
      .d          (cell_d),
      .borrow_out (cell_bout)
   );

   // Result shift register: new bit enters at the MSB, older bits move right.
   always_comb begin
      diff_sh_nxt = '0;
      for (int i = 0; i < W - 1; i++) begin
         diff_sh_nxt[i] = diff_sh[i+1];
      end
      diff_sh_nxt[W-1] = cell_d;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, start acceptance and status outputs.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, per-bit shifting, and result publication on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
         diff    <= '0;
         bout    <= 1'b0;
`ifdef FS_SERIAL_SUB_OVF_EN
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else if (accept) begin
         a_sh    <= a;
         b_sh    <= b;
         borrow  <= bin;
         cnt     <= '0;
`ifdef FS_SERIAL_SUB_OVF_EN
         a_msb   <= a[W-1];
         b_msb   <= b[W-1];
`endif
      end else if (state == RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         diff_sh <= diff_sh_nxt;
         borrow  <= cell_bout;
         if (finish) begin
            diff <= diff_sh_nxt;
            bout <= cell_bout;
`ifdef FS_SERIAL_SUB_OVF_EN
            ovf  <= (a_msb ^ b_msb) & (a_msb ^ diff_sh_nxt[W-1]);
`endif
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fs_serial_sub_ctrl.sv
// Self-checking bench for fs_serial_sub_ctrl (W=8 and W=1 instances).
// Latency: expects done W+1 cycles after an accepted start.
// Backpressure: exercises start during RUN and start held in DONE.
module tb_fs_serial_sub_ctrl;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       bin = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       bin1 = 1'b0;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       bout1;
   logic       ovf1;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];

   always #5 clk = ~clk;

   fs_serial_sub_ctrl #(.W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
`ifdef FS_SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   fs_serial_sub_ctrl #(.W(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .bin   (bin1),
      .busy  (busy1),
      .done  (done1),
      .diff  (diff1),
`ifdef FS_SERIAL_SUB_OVF_EN
      .ovf   (ovf1),
`endif
      .bout  (bout1)
   );

`ifndef FS_SERIAL_SUB_OVF_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   // Reference: 9-bit unsigned subtraction gives the borrow in bit 8.
   function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      exp_t       m;
      logic [8:0] r;
      r      = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
      m.diff = r[7:0];
      m.bout = r[8];
      m.ovf  = (av[7] ^ bv[7]) & (av[7] ^ r[7]);
      return m;
   endfunction

   // Drive a start at the current negedge and queue its expected result.
   // Returns at the negedge of cycle 1 of the operation.
   task automatic drive_start(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      a     = av;
      b     = bv;
      bin   = bi;
      start = 1'b1;
      sb.push_back(model8(av, bv, bi));
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      bin   = $urandom;
   endtask

   // Wait (bounded) for done; reports cycle index of done and busy cycles seen.
   task automatic wait_done(output int cyc, output int bcnt, output bit to);
      cyc  = 1;
      bcnt = 0;
      to   = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) bcnt++;
         if (cyc >= 40) begin
            to = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
      checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || bout1 !== 1'b0) begin
         failures++; $display("FAIL reset_w1 got=%b%b%b%b exp=0000", busy1, done1, diff1, bout1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One operation with latency, busy width, done pulse width and result checks.
   task automatic test_basic(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      int   cyc;
      int   bcnt;
      bit   to;
      exp_t e;
      drive_start(av, bv, bi);
      wait_done(cyc, bcnt, to);
      checks++; if (to || cyc != 9) begin failures++; $display("FAIL basic_latency a=%h b=%h got=%0d exp=9", av, bv, cyc); end
      checks++; if (bcnt != 8) begin failures++; $display("FAIL basic_busy_cycles a=%h b=%h got=%0d exp=8", av, bv, bcnt); end
      if (sb.size() == 0) begin
         checks++; failures++; $display("FAIL basic_scoreboard_empty got=0 exp=1");
      end else begin
         e = sb.pop_front();
         checks++; if (diff !== e.diff) begin failures++; $display("FAIL basic_diff a=%h b=%h bin=%b got=%h exp=%h", av, bv, bi, diff, e.diff); end
         checks++; if (bout !== e.bout) begin failures++; $display("FAIL basic_bout a=%h b=%h bin=%b got=%b exp=%b", av, bv, bi, bout, e.bout); end
`ifdef FS_SERIAL_SUB_OVF_EN
         checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL basic_ovf a=%h b=%h got=%b exp=%b", av, bv, ovf, e.ovf); end
`endif
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after_done got=%b%b exp=00", done, busy); end
   endtask

   task automatic test_start_ignored;
      int   done_cnt;
      int   done_cyc;
      logic [7:0] dsave;
      logic       bsave;
      exp_t e;
      done_cnt = 0;
      done_cyc = 0;
      dsave    = '0;
      bsave    = 1'b0;
      drive_start(8'hC7, 8'h2B, 1'b1);
      for (int c = 1; c <= 14; c++) begin
         if (c == 3 || c == 5) begin
            start = 1'b1; a = 8'hFF; b = 8'h11; bin = 1'b0;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
            dsave    = diff;
            bsave    = bout;
         end
         @(negedge clk);
      end
      start = 1'b0;
      e = sb.pop_front();
      checks++; if (done_cnt != 1 || done_cyc != 9) begin failures++; $display("FAIL ignore_done_count got=%0d@%0d exp=1@9", done_cnt, done_cyc); end
      checks++; if (dsave !== e.diff || bsave !== e.bout) begin failures++; $display("FAIL ignore_result got=%h/%b exp=%h/%b", dsave, bsave, e.diff, e.bout); end
   endtask

   task automatic test_back_to_back;
      int   cyc;
      int   bcnt;
      bit   to;
      int   held_bad;
      exp_t e1;
      exp_t e2;
      drive_start(8'h5A, 8'h3C, 1'b0);
      wait_done(cyc, bcnt, to);
      e1 = sb.pop_front();
      checks++; if (to || diff !== e1.diff || bout !== e1.bout) begin failures++; $display("FAIL b2b_first got=%h/%b exp=%h/%b", diff, bout, e1.diff, e1.bout); end
      drive_start(8'h03, 8'h05, 1'b0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap got=%b exp=1", busy); end
      held_bad = 0;
      cyc      = 1;
      while (done !== 1'b1 && cyc < 40) begin
         if (diff !== e1.diff || bout !== e1.bout) held_bad++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (held_bad != 0) begin failures++; $display("FAIL b2b_held got=%0d exp=0", held_bad); end
      checks++; if (cyc != 9) begin failures++; $display("FAIL b2b_latency got=%0d exp=9", cyc); end
      e2 = sb.pop_front();
      checks++; if (diff !== 8'hFE || bout !== 1'b1 || diff !== e2.diff) begin failures++; $display("FAIL b2b_second got=%h/%b exp=fe/1", diff, bout); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      drive_start(8'hC3, 8'h15, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_status got=%b%b exp=00", busy, done); end
      checks++; if (diff !== 8'h00 || bout !== 1'b0) begin failures++; $display("FAIL midrst_result got=%h/%b exp=00/0", diff, bout); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b%b exp=00", busy, done); end
      test_basic(8'h81, 8'h7E, 1'b1);
   endtask

   task automatic test_w1;
      int cyc;
      a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL w1_busy got=%b exp=1", busy1); end
      cyc = 1;
      while (done1 !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (cyc != 2) begin failures++; $display("FAIL w1_latency got=%0d exp=2", cyc); end
      checks++; if (diff1 !== 1'b1 || bout1 !== 1'b1) begin failures++; $display("FAIL w1_result got=%b/%b exp=1/1", diff1, bout1); end
`ifdef FS_SERIAL_SUB_OVF_EN
      checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL w1_ovf got=%b exp=1", ovf1); end
`endif
      @(negedge clk);
      checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL w1_after got=%b%b exp=00", done1, busy1); end
   endtask

   initial begin
      test_reset();
      test_basic(8'h5A, 8'h3C, 1'b0);
      test_basic(8'h00, 8'h01, 1'b0);
      test_basic(8'h10, 8'h0F, 1'b1);
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_w1();
      test_basic(8'h80, 8'h01, 1'b0);
      test_basic(8'h05, 8'h03, 1'b0);
      for (int i = 0; i < 4; i++) begin
         test_basic(8'($urandom), 8'($urandom), 1'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
